// File: rtl/piso_serializer_if.sv
// Parallel-in/serial-out serializer bus: word-side load handshake, line-side
// bit-rate tick and the serial bit stream with its frame flags.
// master: producer / line-driver side.  slave: the serializer.
interface piso_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] parallel_in;
    logic             load_valid;
    logic             load_ready;
    logic             shift_en;
    logic             serial_out;
    logic             serial_valid;
    logic             serial_last;
    logic             busy;

    modport master (
        output parallel_in,
        output load_valid,
        output shift_en,
        input  load_ready,
        input  serial_out,
        input  serial_valid,
        input  serial_last,
        input  busy
    );

    modport slave (
        input  parallel_in,
        input  load_valid,
        input  shift_en,
        output load_ready,
        output serial_out,
        output serial_valid,
        output serial_last,
        output busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with load handshake and shift-enable.
// A WIDTH-bit word is emitted one bit per shift_en cycle, LSB- or MSB-first,
// with serial_valid/serial_last flags. Back-to-back words run gap-free: the
// next word is accepted in the cycle the last bit is shifted out.
// Optional feature: define PISO_PARITY_EN to append an even-parity bit
// (XOR of the data bits, latched at load) after the data bits.
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b0
) (
    input logic               clk,
    input logic               rst,
    piso_serializer_if.slave  bus
);

`ifdef PISO_PARITY_EN
    localparam int unsigned FLEN = WIDTH + 1;
`else
    localparam int unsigned FLEN = WIDTH;
`endif
    localparam int unsigned      CNT_W    = $clog2(FLEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FLEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // Bit position that drives serial_out; the register shifts toward it.
    localparam int unsigned      OUT_IDX  = MSB_FIRST ? FLEN - 1 : 0;

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    state_e            state_q;
    logic [FLEN-1:0]   sr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              valid_q;
    logic              last_q;
    logic              load_accept;
    logic              shift_step;

    // Frame image: parity (if any) sits at the far end so it leaves last.
    function automatic logic [FLEN-1:0] frame_of(input logic [WIDTH-1:0] word);
`ifdef PISO_PARITY_EN
        if (MSB_FIRST) begin
            return {word, ^word};
        end else begin
            return {^word, word};
        end
`else
        return word;
`endif
    endfunction

    // Handshake: accept in IDLE, or in the last-bit cycle when it is shifted out.
    always_comb begin
        bus.load_ready = (state_q == StIdle) || (last_q && bus.shift_en);
        load_accept    = bus.load_valid && bus.load_ready;
        shift_step     = (state_q == StShift) && bus.shift_en;
    end

    // Frame FSM with shift register, bit counter and registered flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            sr_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (load_accept) begin
            state_q <= StShift;
            sr_q    <= frame_of(bus.parallel_in);
            cnt_q   <= '0;
            valid_q <= 1'b1;
            last_q  <= 1'b0;
        end else if (shift_step) begin
            if (last_q) begin
                // Frame done and no follow-on word: back to IDLE with a quiet line.
                state_q <= StIdle;
                sr_q    <= '0;
                cnt_q   <= '0;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end else begin
                cnt_q  <= cnt_q + CNT_ONE;
                last_q <= ((cnt_q + CNT_ONE) == LAST_CNT);
                if (MSB_FIRST) begin
                    sr_q <= sr_q << 1;
                end else begin
                    sr_q <= sr_q >> 1;
                end
            end
        end
    end

    // Outputs come straight from flops; sr_q is all-zero whenever IDLE.
    always_comb begin
        bus.serial_out   = sr_q[OUT_IDX];
        bus.serial_valid = valid_q;
        bus.serial_last  = last_q;
        bus.busy         = (state_q == StShift);
    end

endmodule
